// File: rtl/gemm_pkg.sv
// Shared widths and FSM encoding for the GEMM accumulator writeback stage.
package gemm_pkg;

   localparam int INP_DEPTH  = 16;
   localparam int ACC_WIDTH  = 32;
   localparam int OUT_WIDTH  = 8;
   localparam int ADDR_WIDTH = 8;
   localparam int AT_WIDTH   = ACC_WIDTH * INP_DEPTH;
   localparam int OT_WIDTH   = OUT_WIDTH * INP_DEPTH;

   // Writeback FSM encoding: IDLE accepts, RD fetches the stored row, WR commits.
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RD   = 2'd1;
   localparam logic [1:0] ST_WR   = 2'd2;

endpackage

// File: rtl/gemm_lane_sat.sv
// Signed clamp of one accumulator lane to the narrower output-buffer lane.
module gemm_lane_sat
   import gemm_pkg::*;
#(
   parameter int IN_W  = ACC_WIDTH,
   parameter int OUT_W = OUT_WIDTH
) (
   input  logic signed [IN_W-1:0]  din_i,
   output logic signed [OUT_W-1:0] dout_o
);

   // Largest and smallest values representable in OUT_W bits, sign-extended to IN_W.
   localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   // Clamp to the output range; in-range values pass through truncated.
   always_comb begin
      if (din_i > SAT_MAX) begin
         dout_o = SAT_MAX[OUT_W-1:0];
      end else if (din_i < SAT_MIN) begin
         dout_o = SAT_MIN[OUT_W-1:0];
      end else begin
         dout_o = din_i[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/gemm_acc_store.sv
// Accumulator writeback: overwrite or read-modify-write one BRAM row per
// transaction and mirror a saturated 8-bit copy into the output buffer.
module gemm_acc_store
   import gemm_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [AT_WIDTH-1:0]   s_tensor,
   input  logic [ADDR_WIDTH-1:0] s_addr,
   input  logic                  s_accum,
   output logic                  acc_en,
   output logic                  acc_we,
   output logic [ADDR_WIDTH-1:0] acc_addr,
   output logic [AT_WIDTH-1:0]   acc_din,
   input  logic [AT_WIDTH-1:0]   acc_dout,
   output logic                  out_we,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [OT_WIDTH-1:0]   out_din,
   output logic                  done,
   output logic [15:0]           wr_count
);

   logic [1:0]            state_q, state_d;
   logic [AT_WIDTH-1:0]   tensor_q, tensor_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  accum_q, accum_d;
   logic [15:0]           wr_count_q, wr_count_d;
   logic                  accept_s;
   logic                  busy_s;
   logic [AT_WIDTH-1:0]   acc_din_s;

   assign accept_s = s_valid && (state_q == ST_IDLE);
   assign busy_s   = (state_q == ST_RD) || (state_q == ST_WR);

   // Next-state decode: accumulate rows detour through RD to fetch the old row.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (s_valid) begin
               state_d = s_accum ? ST_RD : ST_WR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD:   state_d = ST_WR;
         ST_WR:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Capture the request on acceptance and count rows as they are committed.
   always_comb begin
      if (accept_s) begin
         tensor_d = s_tensor;
         addr_d   = s_addr;
         accum_d  = s_accum;
      end else begin
         tensor_d = tensor_q;
         addr_d   = addr_q;
         accum_d  = accum_q;
      end
      if (state_q == ST_WR) begin
         wr_count_d = wr_count_q + 16'd1;
      end else begin
         wr_count_d = wr_count_q;
      end
   end

   // State and capture registers; reset abandons any in-flight row.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tensor_q   <= '0;
         addr_q     <= '0;
         accum_q    <= 1'b0;
         wr_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         tensor_q   <= tensor_d;
         addr_q     <= addr_d;
         accum_q    <= accum_d;
         wr_count_q <= wr_count_d;
      end
   end

   // Write data: per-lane wrapping add onto the fetched row, or the row itself.
   always_comb begin
      acc_din_s = '0;
      for (int k = 0; k < INP_DEPTH; k++) begin
         if (state_q != ST_WR) begin
            acc_din_s[k*ACC_WIDTH +: ACC_WIDTH] = '0;
         end else if (accum_q) begin
            acc_din_s[k*ACC_WIDTH +: ACC_WIDTH] = tensor_q[k*ACC_WIDTH +: ACC_WIDTH]
                                                + acc_dout[k*ACC_WIDTH +: ACC_WIDTH];
         end else begin
            acc_din_s[k*ACC_WIDTH +: ACC_WIDTH] = tensor_q[k*ACC_WIDTH +: ACC_WIDTH];
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < INP_DEPTH; g++) begin : g_sat
         gemm_lane_sat #(
            .IN_W  (ACC_WIDTH),
            .OUT_W (OUT_WIDTH)
         ) u_sat (
            .din_i  (acc_din_s[g*ACC_WIDTH +: ACC_WIDTH]),
            .dout_o (out_din[g*OUT_WIDTH +: OUT_WIDTH])
         );
      end
   endgenerate

   assign s_ready  = (state_q == ST_IDLE);
   assign acc_en   = busy_s;
   assign acc_we   = (state_q == ST_WR);
   assign acc_addr = busy_s ? addr_q : '0;
   assign acc_din  = acc_din_s;
   assign out_we   = (state_q == ST_WR);
   assign out_addr = acc_addr;
   assign done     = (state_q == ST_WR);
   assign wr_count = wr_count_q;

endmodule

// File: tb/tb_gemm_acc_store.sv
// Self-checking bench for gemm_acc_store: directed table, randomized rows
// against a row-level memory model, backpressure and mid-transaction reset.
module tb_gemm_acc_store;
   import gemm_pkg::*;

   logic                  clk;
   logic                  rst;
   logic                  s_valid;
   logic                  s_ready;
   logic [AT_WIDTH-1:0]   s_tensor;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic                  s_accum;
   logic                  acc_en;
   logic                  acc_we;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [AT_WIDTH-1:0]   acc_din;
   logic [AT_WIDTH-1:0]   acc_dout;
   logic                  out_we;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic [OT_WIDTH-1:0]   out_din;
   logic                  done;
   logic [15:0]           wr_count;

   gemm_acc_store dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_tensor (s_tensor),
      .s_addr   (s_addr),
      .s_accum  (s_accum),
      .acc_en   (acc_en),
      .acc_we   (acc_we),
      .acc_addr (acc_addr),
      .acc_din  (acc_din),
      .acc_dout (acc_dout),
      .out_we   (out_we),
      .out_addr (out_addr),
      .out_din  (out_din),
      .done     (done),
      .wr_count (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port BRAM with one-cycle registered read.
   logic [AT_WIDTH-1:0] bram [0:255];
   always @(posedge clk) begin
      if (acc_en) begin
         if (acc_we) bram[acc_addr] <= acc_din;
         else        acc_dout <= bram[acc_addr];
      end
   end

   // Reference contents of the accumulator memory, lane by lane.
   logic signed [31:0] ref_mem [0:255][0:15];

   int        n_vec;
   int        n_err;
   logic [15:0] exp_cnt;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [AT_WIDTH-1:0] rep_acc(input logic [31:0] v);
      logic [AT_WIDTH-1:0] r;
      for (int k = 0; k < INP_DEPTH; k++) r[k*32 +: 32] = v;
      return r;
   endfunction

   function automatic logic [OT_WIDTH-1:0] rep_out(input logic [7:0] v);
      logic [OT_WIDTH-1:0] r;
      for (int k = 0; k < INP_DEPTH; k++) r[k*8 +: 8] = v;
      return r;
   endfunction

   // Expected row from the model: wrapping 32-bit add, then clamp to [-128,127].
   task automatic model_row(input logic [7:0] addr, input logic accum, input logic [AT_WIDTH-1:0] t,
                            output logic [AT_WIDTH-1:0] e_din, output logic [OT_WIDTH-1:0] e_out);
      logic signed [31:0] a;
      for (int k = 0; k < INP_DEPTH; k++) begin
         a = t[k*32 +: 32];
         if (accum) a = a + ref_mem[addr][k];
         e_din[k*32 +: 32] = a;
         if (a > 32'sd127)       e_out[k*8 +: 8] = 8'h7F;
         else if (a < -32'sd128) e_out[k*8 +: 8] = 8'h80;
         else                    e_out[k*8 +: 8] = a[7:0];
      end
   endtask

   task automatic commit(input logic [7:0] addr, input logic [AT_WIDTH-1:0] row);
      for (int k = 0; k < INP_DEPTH; k++) ref_mem[addr][k] = row[k*32 +: 32];
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      s_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_cnt = 16'd0;
   endtask

   // One transaction through the handshake, checking RD and WR cycles.
   task automatic run_txn(input logic [7:0] addr, input logic accum, input logic [AT_WIDTH-1:0] t,
                          input logic [AT_WIDTH-1:0] e_din, input logic [OT_WIDTH-1:0] e_out);
      int n = 0;
      while (!s_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 512'(s_ready), 512'(1'b1));
      s_valid  = 1'b1;
      s_addr   = addr;
      s_accum  = accum;
      s_tensor = t;
      @(posedge clk);
      @(negedge clk);
      s_valid  = 1'b0;
      s_addr   = 8'($urandom);
      s_accum  = 1'($urandom);
      for (int k = 0; k < INP_DEPTH; k++) s_tensor[k*32 +: 32] = $urandom;
      if (accum) begin
         chk("rd_ready", 512'(s_ready), 512'(1'b0));
         chk("rd_en",    512'(acc_en),  512'(1'b1));
         chk("rd_we",    512'(acc_we),  512'(1'b0));
         chk("rd_addr",  512'(acc_addr), 512'(addr));
         chk("rd_done",  512'({out_we, done}), 512'(2'b00));
         @(negedge clk);
      end
      chk("wr_ctl",   512'({s_ready, acc_en, acc_we, out_we, done}), 512'(5'b01111));
      chk("wr_addr",  512'({acc_addr, out_addr}), 512'({addr, addr}));
      chk("acc_din",  512'(acc_din), 512'(e_din));
      chk("out_din",  512'(out_din), 512'(e_out));
      chk("wr_cnt_in", 512'(wr_count), 512'(exp_cnt));
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      chk("idle_after", 512'({s_ready, acc_we, done}), 512'(3'b100));
      chk("wr_cnt",   512'(wr_count), 512'(exp_cnt));
      commit(addr, e_din);
   endtask

   typedef struct {
      logic [7:0]         addr;
      logic               accum;
      logic signed [31:0] val;
      logic signed [31:0] exp_acc;
      logic signed [7:0]  exp_out;
   } vec_t;

   vec_t tbl [0:7];

   initial begin
      logic [AT_WIDTH-1:0] t;
      logic [AT_WIDTH-1:0] e_din;
      logic [OT_WIDTH-1:0] e_out;
      logic [7:0]          a;
      logic                m;
      int accepts, dones, last_acc, c;
      logic [AT_WIDTH-1:0] saved;

      n_vec = 0;
      n_err = 0;
      exp_cnt = 16'd0;
      rst = 1'b1;
      s_valid = 1'b0;
      s_addr = '0;
      s_accum = 1'b0;
      s_tensor = '0;
      for (int i = 0; i < 256; i++) begin
         bram[i] = '0;
         for (int k = 0; k < INP_DEPTH; k++) ref_mem[i][k] = 32'sd0;
      end

      tbl[0] = '{8'd5, 1'b0,  32'sd100,         32'sd100,         8'sd127 - 8'sd27};
      tbl[1] = '{8'd5, 1'b1,  32'sd50,          32'sd150,         8'sd127};
      tbl[2] = '{8'd6, 1'b0, -32'sd200,        -32'sd200,        -8'sd128};
      tbl[3] = '{8'd6, 1'b1, -32'sd10,         -32'sd210,        -8'sd128};
      tbl[4] = '{8'd7, 1'b0,  32'sh7FFFFFFF,    32'sh7FFFFFFF,    8'sd127};
      tbl[5] = '{8'd7, 1'b1,  32'sd1,           32'sh80000000,   -8'sd128};
      tbl[6] = '{8'd8, 1'b0, -32'sd5,          -32'sd5,          -8'sd5};
      tbl[7] = '{8'd8, 1'b1,  32'sd3,          -32'sd2,          -8'sd2};

      // Reset then idle.
      reset_dut();
      chk("rst_ctl",  512'({s_ready, acc_en, acc_we, out_we, done}), 512'(5'b10000));
      chk("rst_cnt",  512'(wr_count), 512'(16'd0));
      chk("rst_data", 512'({acc_addr, acc_din, out_din} != '0), 512'(1'b0));

      // Directed table: overwrite, accumulate, saturation and wrap.
      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].addr, tbl[i].accum, rep_acc(tbl[i].val),
                 rep_acc(tbl[i].exp_acc), rep_out(tbl[i].exp_out));
      end

      // Randomized rows against the memory model; small address range forces reuse.
      for (int i = 0; i < 40; i++) begin
         a = 8'($urandom_range(0, 7));
         m = 1'($urandom);
         for (int k = 0; k < INP_DEPTH; k++) begin
            if ($urandom_range(0, 1) == 0) t[k*32 +: 32] = $urandom;
            else t[k*32 +: 32] = 32'(int'($urandom_range(0, 600)) - 300);
         end
         model_row(a, m, t, e_din, e_out);
         run_txn(a, m, t, e_din, e_out);
      end

      // Backpressure: s_valid held across three overwrite rows.
      reset_dut();
      accepts = 0;
      dones = 0;
      last_acc = -10;
      s_valid = 1'b1;
      s_accum = 1'b0;
      s_addr = 8'd20;
      s_tensor = rep_acc(32'd1);
      for (c = 0; c < 12; c++) begin
         if (done) begin
            dones++;
            chk("bp_ready_in_wr", 512'(s_ready), 512'(1'b0));
         end
         if (s_valid && s_ready) begin
            if (accepts > 0) chk("bp_gap", 512'(c - last_acc), 512'(2));
            last_acc = c;
            commit(s_addr, s_tensor);
            accepts++;
            @(posedge clk);
            @(negedge clk);
            if (accepts == 3) s_valid = 1'b0;
            s_addr = 8'(20 + accepts);
            s_tensor = rep_acc(32'(accepts + 1));
         end else begin
            @(negedge clk);
         end
      end
      chk("bp_accepts", 512'(accepts), 512'(3));
      chk("bp_dones",   512'(dones),   512'(3));
      chk("bp_wr_cnt",  512'(wr_count), 512'(16'd3));
      exp_cnt = 16'd3;

      // Reset in the RD cycle drops the pending write.
      saved = bram[8'd5];
      s_valid = 1'b1;
      s_accum = 1'b1;
      s_addr = 8'd5;
      s_tensor = rep_acc(32'd7);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      chk("mid_rd", 512'({acc_en, acc_we}), 512'(2'b10));
      rst = 1'b1;
      @(negedge clk);
      chk("mid_ctl", 512'({s_ready, acc_we, out_we, done}), 512'(4'b1000));
      chk("mid_cnt", 512'(wr_count), 512'(16'd0));
      rst = 1'b0;
      exp_cnt = 16'd0;
      @(negedge clk);
      chk("mid_mem", 512'(bram[8'd5]), 512'(saved));
      t = rep_acc(32'd7);
      model_row(8'd5, 1'b1, t, e_din, e_out);
      run_txn(8'd5, 1'b1, t, e_din, e_out);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
